am_mult_arbiter: RTL

AM_MULT_ARBITER -- requirements
Module: am_mult_arbiter

---
 rtl/am_mult_arbiter_pkg.sv | 15 +
 rtl/am_mult_arbiter_if.sv | 42 ++++
 rtl/am_mult_arbiter_pipe.sv | 69 ++++++
 rtl/am_mult_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/am_mult_arbiter_pkg.sv
// Shared constants and helpers for the round-robin multiplier arbiter.
package am_pkg;

  localparam int unsigned AM_N_REQ_DEF     = 4;
  localparam int unsigned AM_CARRIER_W_DEF = 8;
  localparam int unsigned AM_SIGNAL_W_DEF  = 8;
  localparam int unsigned AM_OUT_W_DEF     = 8;
  localparam int unsigned AM_MULT_LAT      = 2;
  localparam int unsigned AM_GRANT_CNT_W   = 16;

  function automatic int unsigned am_min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/am_mult_arbiter_if.sv
// Request/response bus between requesters and the shared multiplier.
// grant_cnt exists only when AM_ARB_GRANT_CNT_EN is defined.
interface am_mult_arbiter_if
  import am_pkg::*;
#(
  parameter int unsigned N_REQ     = AM_N_REQ_DEF,
  parameter int unsigned CARRIER_W = AM_CARRIER_W_DEF,
  parameter int unsigned SIGNAL_W  = AM_SIGNAL_W_DEF,
  parameter int unsigned OUT_W     = AM_OUT_W_DEF
) ();

  localparam int unsigned RW = am_min(CARRIER_W + SIGNAL_W, OUT_W);

  logic                          enable;
  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ*CARRIER_W-1:0]    req_carrier;
  logic [N_REQ*SIGNAL_W-1:0]     req_signal;
  logic [N_REQ-1:0]              req_ready;
  logic [N_REQ-1:0]              rsp_valid;
  logic [RW-1:0]                 rsp_data;
  logic                          busy;
`ifdef AM_ARB_GRANT_CNT_EN
  logic [N_REQ*AM_GRANT_CNT_W-1:0] grant_cnt;
`endif

  modport slave (
    input  enable, req_valid, req_carrier, req_signal,
`ifdef AM_ARB_GRANT_CNT_EN
    output grant_cnt,
`endif
    output req_ready, rsp_valid, rsp_data, busy
  );

  modport master (
    output enable, req_valid, req_carrier, req_signal,
`ifdef AM_ARB_GRANT_CNT_EN
    input  grant_cnt,
`endif
    input  req_ready, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/am_mult_arbiter_pipe.sv
// Two-stage unsigned multiplier: operand register then product register,
// with a valid bit and requester index travelling alongside the data.
module am_mult_pipe #(
  parameter int unsigned CARRIER_W = 8,
  parameter int unsigned SIGNAL_W  = 8,
  parameter int unsigned RW        = 8,
  parameter int unsigned IDX_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [IDX_W-1:0]     i_idx,
  input  logic [CARRIER_W-1:0] i_carrier,
  input  logic [SIGNAL_W-1:0]  i_signal,
  output logic                 o_valid,
  output logic [IDX_W-1:0]     o_idx,
  output logic [RW-1:0]        o_data,
  output logic                 o_busy
);

  logic                 r_s1_valid;
  logic [IDX_W-1:0]     r_s1_idx;
  logic [CARRIER_W-1:0] r_s1_carrier;
  logic [SIGNAL_W-1:0]  r_s1_signal;
  logic                 r_s2_valid;
  logic [IDX_W-1:0]     r_s2_idx;
  logic [RW-1:0]        r_s2_data;
  logic [RW-1:0]        w_prod;

  // Low RW bits of a product depend only on the low RW bits of each operand.
  assign w_prod = RW'(r_s1_carrier) * RW'(r_s1_signal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_idx     <= '0;
      r_s1_carrier <= '0;
      r_s1_signal  <= '0;
    end else begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_idx     <= i_idx;
        r_s1_carrier <= i_carrier;
        r_s1_signal  <= i_signal;
      end
    end
  end

  // Product register only loads on a valid beat so the bus holds its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_idx   <= '0;
      r_s2_data  <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_idx  <= r_s1_idx;
        r_s2_data <= w_prod;
      end
    end
  end

  assign o_valid = r_s2_valid;
  assign o_idx   = r_s2_idx;
  assign o_data  = r_s2_data;
  assign o_busy  = r_s1_valid | r_s2_valid;

endmodule

// File: rtl/am_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among N_REQ requesters.
// Optional per-requester grant counters enabled by AM_ARB_GRANT_CNT_EN.
module am_mult_arbiter
  import am_pkg::*;
#(
  parameter int unsigned N_REQ     = AM_N_REQ_DEF,
  parameter int unsigned CARRIER_W = AM_CARRIER_W_DEF,
  parameter int unsigned SIGNAL_W  = AM_SIGNAL_W_DEF,
  parameter int unsigned OUT_W     = AM_OUT_W_DEF
) (
  input logic             clk,
  input logic             rst,
  am_mult_arbiter_if.slave bus
);

  localparam int unsigned RW    = am_min(CARRIER_W + SIGNAL_W, OUT_W);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     w_ptr_nxt;
  logic [IDX_W-1:0]     w_scan;
  logic [IDX_W-1:0]     w_grant_idx;
  logic                 w_found;
  logic [N_REQ-1:0]     w_grant;
  logic [CARRIER_W-1:0] w_carrier;
  logic [SIGNAL_W-1:0]  w_signal;
  logic                 w_pipe_valid;
  logic [IDX_W-1:0]     w_pipe_idx;
  logic [RW-1:0]        w_pipe_data;
  logic                 w_pipe_busy;
  logic [N_REQ-1:0]     w_rsp_valid;

  // First valid requester at or after the pointer wins; gated off in reset.
  always_comb begin
    w_scan      = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_grant     = '0;
    if (!rst && bus.enable) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        w_scan = IDX_W'((32'(r_ptr) + k) % N_REQ);
        if (!w_found && bus.req_valid[w_scan]) begin
          w_found     = 1'b1;
          w_grant_idx = w_scan;
        end
      end
    end
    if (w_found) begin
      w_grant[w_grant_idx] = 1'b1;
    end
  end

  assign w_ptr_nxt = (w_grant_idx == IDX_W'(N_REQ - 1)) ? '0 : w_grant_idx + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign w_carrier = bus.req_carrier[w_grant_idx*CARRIER_W +: CARRIER_W];
  assign w_signal  = bus.req_signal[w_grant_idx*SIGNAL_W +: SIGNAL_W];

  am_mult_pipe #(
    .CARRIER_W (CARRIER_W),
    .SIGNAL_W  (SIGNAL_W),
    .RW        (RW),
    .IDX_W     (IDX_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (w_found),
    .i_idx     (w_grant_idx),
    .i_carrier (w_carrier),
    .i_signal  (w_signal),
    .o_valid   (w_pipe_valid),
    .o_idx     (w_pipe_idx),
    .o_data    (w_pipe_data),
    .o_busy    (w_pipe_busy)
  );

  always_comb begin
    w_rsp_valid = '0;
    if (w_pipe_valid) begin
      w_rsp_valid[w_pipe_idx] = 1'b1;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = w_pipe_data;
  assign bus.busy      = w_pipe_busy;

`ifdef AM_ARB_GRANT_CNT_EN
  logic [N_REQ-1:0][AM_GRANT_CNT_W-1:0] r_grant_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (w_grant[i]) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + AM_GRANT_CNT_W'(1);
        end
      end
    end
  end

  assign bus.grant_cnt = r_grant_cnt;
`endif

endmodule
